// File: rtl/flash_stream_loader.sv
// SPI-flash streamer: issues READ (0x03) at a slot base address and packs the
// returned bytes little-endian into DATA_BYTES-wide words behind a ready/valid register.
module flash_stream_loader #(
  parameter logic [23:0] BASE_ADDR  = 24'h400000,
  parameter int          SLOT_BITS  = 4,
  parameter int          SLOT_SHIFT = 18,
  parameter int          LEN_BITS   = 22,
  parameter int          DATA_BYTES = 1,
  parameter int          CLK_DIV    = 2,
  parameter int          CS_GAP     = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [SLOT_BITS-1:0]    i_slot,
  input  logic [LEN_BITS-1:0]     i_length,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_flash_csn,
  output logic                    o_flash_sck,
  output logic                    o_flash_mosi,
  input  logic                    i_flash_miso,
  output logic [8*DATA_BYTES-1:0] o_out_data,
  output logic [LEN_BITS-1:0]     o_out_addr,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_out_last
);
  localparam int WW   = 8 * DATA_BYTES;
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAPW = $clog2(CS_GAP + 1);
  localparam int BIW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_CMD, S_ADDR, S_DATA, S_HOLD, S_FINISH} state_t;
  state_t r_state, w_state_nx;

  logic                 r_busy, r_done, r_csn, r_sck;
  logic [DIVW-1:0]      r_div;
  logic [GAPW-1:0]      r_gap;
  logic [4:0]           r_bitcnt;
  logic [31:0]          r_sh_out;
  logic [7:0]           r_sh_in;
  logic [SLOT_BITS-1:0] r_slot;
  logic [LEN_BITS-1:0]  r_left, r_waddr, r_out_addr;
  logic [BIW-1:0]       r_bidx;
  logic [WW-1:0]        r_word, r_out_data;
  logic                 r_pend, r_pend_last, r_out_valid, r_out_last;

  logic w_run, w_tick, w_rise, w_fall, w_gap_end, w_cmd_end, w_addr_end, w_byte_end;
  logic w_last_byte, w_word_done, w_free, w_load_now, w_load_pend;
  logic [23:0]   w_faddr;
  logic [31:0]   w_hdr;
  logic [WW-1:0] w_word_val;

  assign w_run       = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_tick      = (r_div == DIVW'(CLK_DIV - 1));
  assign w_rise      = w_run && w_tick && !r_sck;
  assign w_fall      = w_run && w_tick && r_sck;
  assign w_gap_end   = (r_state == S_GAP) && (r_gap == GAPW'(CS_GAP - 1));
  assign w_cmd_end   = (r_state == S_CMD) && w_fall && (r_bitcnt == 5'd7);
  assign w_addr_end  = (r_state == S_ADDR) && w_fall && (r_bitcnt == 5'd23);
  assign w_byte_end  = (r_state == S_DATA) && w_fall && (r_bitcnt == 5'd7);
  assign w_last_byte = (r_left == LEN_BITS'(1));
  assign w_word_done = w_byte_end && (w_last_byte || (r_bidx == BIW'(DATA_BYTES - 1)));
  assign w_free      = !r_out_valid || i_out_ready;
  assign w_load_now  = w_word_done && w_free;
  assign w_load_pend = r_pend && w_free;
  assign w_faddr     = BASE_ADDR + (24'(r_slot) << SLOT_SHIFT);
  assign w_hdr       = {8'h03, w_faddr};
  assign w_word_val  = r_word | (WW'(r_sh_in) << {r_bidx, 3'b000});

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nx = (i_length == '0) ? S_FINISH : S_GAP;
      S_GAP:    if (w_gap_end) w_state_nx = S_CMD;
      S_CMD:    if (w_cmd_end) w_state_nx = S_ADDR;
      S_ADDR:   if (w_addr_end) w_state_nx = S_DATA;
      S_DATA: begin
        // a completed word that cannot be stored parks the bus on a byte boundary
        if (w_byte_end) begin
          if (w_last_byte)                 w_state_nx = S_FINISH;
          else if (w_word_done && !w_free) w_state_nx = S_HOLD;
        end
      end
      S_HOLD:   if (w_free) w_state_nx = S_DATA;
      S_FINISH: if (!r_pend && w_free) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_csn       <= 1'b1;
      r_sck       <= 1'b0;
      r_div       <= '0;
      r_gap       <= '0;
      r_bitcnt    <= '0;
      r_sh_out    <= '0;
      r_sh_in     <= '0;
      r_slot      <= '0;
      r_left      <= '0;
      r_bidx      <= '0;
      r_word      <= '0;
      r_waddr     <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= 1'b0;
      r_csn   <= !(w_state_nx inside {S_CMD, S_ADDR, S_DATA, S_HOLD});
      r_gap   <= (r_state == S_GAP) ? r_gap + GAPW'(1) : '0;

      if ((r_state == S_IDLE) && i_start) begin
        r_busy  <= 1'b1;
        r_slot  <= i_slot;
        r_left  <= i_length;
        r_bidx  <= '0;
        r_word  <= '0;
        r_waddr <= '0;
        r_pend  <= 1'b0;
      end
      if ((r_state == S_FINISH) && (w_state_nx == S_IDLE)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end

      // csn drops with sck low, so the first rise is a full half-period later
      if (w_gap_end) begin
        r_sh_out <= w_hdr;
        r_bitcnt <= '0;
        r_div    <= '0;
        r_sck    <= 1'b0;
      end else if (w_run) begin
        r_div <= w_tick ? '0 : r_div + DIVW'(1);
        if (w_rise) begin
          r_sck   <= 1'b1;
          r_sh_in <= {r_sh_in[6:0], i_flash_miso};
        end
        if (w_fall) begin
          r_sck    <= 1'b0;
          r_sh_out <= {r_sh_out[30:0], 1'b0};
          r_bitcnt <= (w_cmd_end || w_addr_end || w_byte_end) ? '0 : r_bitcnt + 5'd1;
        end
      end else begin
        r_div <= '0;
        r_sck <= 1'b0;
      end

      if (w_byte_end) begin
        r_left <= r_left - LEN_BITS'(1);
        if (w_word_done) begin
          r_bidx      <= '0;
          r_word      <= w_free ? '0 : w_word_val;
          r_pend      <= !w_free;
          r_pend_last <= w_last_byte;
        end else begin
          r_bidx <= r_bidx + BIW'(1);
          r_word <= w_word_val;
        end
      end

      if (w_load_pend) begin
        r_pend <= 1'b0;
        r_word <= '0;
      end
      if (w_load_now || w_load_pend) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_now ? w_word_val : r_word;
        r_out_last  <= w_load_now ? w_last_byte : r_pend_last;
        r_out_addr  <= r_waddr;
        r_waddr     <= r_waddr + LEN_BITS'(DATA_BYTES);
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_flash_csn  = r_csn;
  assign o_flash_sck  = r_sck;
  assign o_flash_mosi = r_sh_out[31];
  assign o_out_data   = r_out_data;
  assign o_out_addr   = r_out_addr;
  assign o_out_valid  = r_out_valid;
  assign o_out_last   = r_out_last;
endmodule

// File: tb/tb_flash_stream_loader.sv
// Bench for flash_stream_loader: a DATA_BYTES=1 and a DATA_BYTES=2 instance share
// the control inputs; each talks to its own SPI flash model fed from a random byte table.
module tb_flash_stream_loader;
  localparam int NW = 0, TXN = 1, DN = 2, STAB = 3, SHI = 4, NV = 5;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, rdy = 1'b1, stall_win = 1'b0;
  logic [3:0]  slot = '0;
  logic [21:0] len = '0;
  logic [1:0]  busy, done, csn, sck, mosi, ovalid, olast;
  logic [15:0] odata [2];
  logic [21:0] oaddr [2];
  logic [7:0]  tbl [256];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [8*(g+1)-1:0] w_od;
    logic        miso = 1'b0;
    logic [31:0] hdr = '0;
    logic [39:0] wq [64];
    logic [37:0] pd = '0;
    logic [7:0]  fb;
    logic        pv = 1'b0, pr = 1'b0;
    int nb = 0, txn = 0, dn = 0, nw = 0, stab_bad = 0, sck_hi = 0, nvalid = 0;

    flash_stream_loader #(.DATA_BYTES(g + 1)) u_dut (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_slot(slot), .i_length(len),
      .o_busy(busy[g]), .o_done(done[g]), .o_flash_csn(csn[g]), .o_flash_sck(sck[g]),
      .o_flash_mosi(mosi[g]), .i_flash_miso(miso), .o_out_data(w_od),
      .o_out_addr(oaddr[g]), .o_out_valid(ovalid[g]), .i_out_ready(rdy),
      .o_out_last(olast[g]));
    assign odata[g] = 16'(w_od);

    // flash: csn fall opens a transaction, 32 header bits in, then data MSB first
    always @(negedge csn[g] or posedge sck[g]) begin
      if (sck[g] === 1'b0) begin
        nb = 0;
        txn++;
      end else if (csn[g] === 1'b0) begin
        if (nb < 32) hdr = {hdr[30:0], mosi[g]};
        nb++;
      end
    end
    always @(negedge sck[g]) begin
      if (csn[g] === 1'b0 && nb >= 32) begin
        fb   = tbl[((nb - 32) / 8) % 256];
        miso = fb[7 - ((nb - 32) % 8)];
      end
    end

    always @(negedge clk) begin
      if (ovalid[g] && rdy) begin
        wq[nw % 64] = {1'b0, olast[g], oaddr[g], odata[g]};
        nw++;
      end
      if (pv && !pr && ovalid[g] && ({oaddr[g], odata[g]} !== pd)) stab_bad++;
      pv = ovalid[g];
      pr = rdy;
      pd = {oaddr[g], odata[g]};
      if (done[g]) dn++;
      if (ovalid[g]) nvalid++;
      if (stall_win && sck[g]) sck_hi++;
    end
  end

  function automatic int mcnt(int g, int k);
    int v [2][6];
    v[0] = '{g_inst[0].nw, g_inst[0].txn, g_inst[0].dn, g_inst[0].stab_bad, g_inst[0].sck_hi, g_inst[0].nvalid};
    v[1] = '{g_inst[1].nw, g_inst[1].txn, g_inst[1].dn, g_inst[1].stab_bad, g_inst[1].sck_hi, g_inst[1].nvalid};
    return v[g][k];
  endfunction
  function automatic logic [31:0] mhdr(int g);
    return (g == 0) ? g_inst[0].hdr : g_inst[1].hdr;
  endfunction
  function automatic logic [39:0] mword(int g, int i);
    return (g == 0) ? g_inst[0].wq[i % 64] : g_inst[1].wq[i % 64];
  endfunction

  // reference model: header bits and the word stream implied by the byte table
  function automatic logic [31:0] exp_hdr(logic [3:0] s);
    logic [31:0] a;
    a = (32'h400000 + (32'(s) << 18)) & 32'h00FF_FFFF;
    return {8'h03, a[23:0]};
  endfunction
  function automatic logic [39:0] exp_word(int db, int w, int n);
    logic [15:0] d;
    int nwords;
    d = '0;
    nwords = (n + db - 1) / db;
    for (int k = 0; k < db; k++) if (w * db + k < n) d[8*k +: 8] = tbl[w * db + k];
    return {1'b0, (w == nwords - 1), 22'(w * db), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill_tbl();
    for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
  endtask

  task automatic xfer(input string nm, input logic [3:0] s, input int n, input int rmode,
                      input int s2_at, input int stall_at, input int stall_len);
    int b [2][6];
    int cyc, db, nwx, got;
    for (int g = 0; g < 2; g++) for (int k = 0; k < 6; k++) b[g][k] = mcnt(g, k);
    start = 1'b1; slot = s; len = 22'(n);
    tick();
    start = 1'b0; slot = 4'($urandom); len = 22'($urandom);
    cyc = 0;
    while (!(mcnt(0, DN) > b[0][DN] && mcnt(1, DN) > b[1][DN]) && cyc < 8000) begin
      cyc++;
      if (cyc == s2_at) begin start = 1'b1; slot = s ^ 4'h5; len = 22'd3; end
      else start = 1'b0;
      if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) rdy = 1'b0;
      else rdy = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      stall_win = (stall_len > 0 && cyc >= stall_at + 100 && cyc < stall_at + stall_len);
      tick();
    end
    start = 1'b0; rdy = 1'b1; stall_win = 1'b0;
    checks++;
    if (cyc >= 8000) begin errors++; $display("FAIL %s timeout: no done after %0d cycles", nm, cyc); end
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      db = g + 1;
      nwx = (n + db - 1) / db;
      checks++;
      if (mhdr(g) !== exp_hdr(s)) begin errors++; $display("FAIL %s hdr db%0d: got %h want %h", nm, db, mhdr(g), exp_hdr(s)); end
      checks++; got = mcnt(g, TXN) - b[g][TXN];
      if (got !== 1) begin errors++; $display("FAIL %s csn_txn db%0d: got %0d want 1", nm, db, got); end
      checks++; got = mcnt(g, NW) - b[g][NW];
      if (got !== nwx) begin errors++; $display("FAIL %s nwords db%0d: got %0d want %0d", nm, db, got, nwx); end
      checks++; got = mcnt(g, DN) - b[g][DN];
      if (got !== 1) begin errors++; $display("FAIL %s done_cnt db%0d: got %0d want 1", nm, db, got); end
      checks++; got = mcnt(g, STAB) - b[g][STAB];
      if (got !== 0) begin errors++; $display("FAIL %s hold_stable db%0d: got %0d changes want 0", nm, db, got); end
      if (stall_len > 0) begin
        checks++; got = mcnt(g, SHI) - b[g][SHI];
        if (got !== 0) begin errors++; $display("FAIL %s sck_stall db%0d: got %0d high cycles want 0", nm, db, got); end
      end
      for (int w = 0; w < nwx; w++) begin
        checks++;
        if (mword(g, b[g][NW] + w) !== exp_word(db, w, n)) begin
          errors++;
          $display("FAIL %s word db%0d #%0d: got %h want %h", nm, db, w, mword(g, b[g][NW] + w), exp_word(db, w, n));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({busy[g], done[g], csn[g], sck[g], mosi[g], ovalid[g], olast[g]} !== 7'b0010000) begin
        errors++;
        $display("FAIL reset ctl db%0d: got %b want 0010000", g + 1, {busy[g], done[g], csn[g], sck[g], mosi[g], ovalid[g], olast[g]});
      end
      checks++;
      if (odata[g] !== 16'h0) begin errors++; $display("FAIL reset data db%0d: got %h want 0", g + 1, odata[g]); end
      checks++;
      if (oaddr[g] !== 22'h0) begin errors++; $display("FAIL reset addr db%0d: got %h want 0", g + 1, oaddr[g]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    fill_tbl();
    for (int i = 0; i < 5; i++) tbl[i] = 8'hA0 + 8'(i);
    xfer("basic", 4'd2, 5, 0, 0, 0, 0);
  endtask

  task automatic test_pack();
    fill_tbl();
    tbl[0] = 8'hAA; tbl[1] = 8'hBB; tbl[2] = 8'hCC;
    xfer("pack", 4'($urandom), 3, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    fill_tbl();
    xfer("stall", 4'($urandom), 8, 0, 0, 180, 200);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      fill_tbl();
      xfer("random", 4'($urandom), $urandom_range(1, 40), 1, 0, 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    fill_tbl();
    xfer("busy_start", 4'd1, 6, 0, 40, 0, 0);
    xfer("b2b", 4'd15, 4, 1, 0, 0, 0);
  endtask

  task automatic test_len0();
    int b [2][6];
    for (int g = 0; g < 2; g++) for (int k = 0; k < 6; k++) b[g][k] = mcnt(g, k);
    start = 1'b1; len = '0; slot = 4'($urandom);
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, csn} !== 6'b110011) begin errors++; $display("FAIL len0 cycle1: got %b want 110011", {busy, done, csn}); end
    tick();
    checks++;
    if ({busy, done, csn} !== 6'b001111) begin errors++; $display("FAIL len0 cycle2: got %b want 001111", {busy, done, csn}); end
    tick();
    checks++;
    if ({busy, done, csn} !== 6'b000011) begin errors++; $display("FAIL len0 cycle3: got %b want 000011", {busy, done, csn}); end
    tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (mcnt(g, TXN) - b[g][TXN] !== 0) begin errors++; $display("FAIL len0 csn db%0d: got %0d txns want 0", g + 1, mcnt(g, TXN) - b[g][TXN]); end
      checks++;
      if (mcnt(g, NV) - b[g][NV] !== 0) begin errors++; $display("FAIL len0 valid db%0d: got %0d want 0", g + 1, mcnt(g, NV) - b[g][NV]); end
      checks++;
      if (mcnt(g, DN) - b[g][DN] !== 1) begin errors++; $display("FAIL len0 done db%0d: got %0d want 1", g + 1, mcnt(g, DN) - b[g][DN]); end
    end
  endtask

  task automatic test_reset_mid();
    int b0, b1, cyc;
    fill_tbl();
    b0 = mcnt(0, DN); b1 = mcnt(1, DN);
    start = 1'b1; slot = 4'd3; len = 22'd30;
    tick();
    start = 1'b0;
    cyc = 0;
    while (ovalid[0] !== 1'b1 && cyc < 2000) begin tick(); cyc++; end
    checks++;
    if (cyc >= 2000) begin errors++; $display("FAIL reset_mid timeout: got no valid in %0d cycles", cyc); end
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({csn, sck, ovalid, busy} !== 8'b11000000) begin
      errors++;
      $display("FAIL reset_mid outputs: got %b want 11000000", {csn, sck, ovalid, busy});
    end
    rst = 1'b0;
    repeat (20) tick();
    checks++;
    if ((mcnt(0, DN) - b0) + (mcnt(1, DN) - b1) !== 0) begin
      errors++;
      $display("FAIL reset_mid done: got %0d pulses want 0", (mcnt(0, DN) - b0) + (mcnt(1, DN) - b1));
    end
    xfer("after_reset", 4'd7, 9, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pack();
    test_len0();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
